// File: rtl/smaesh_sched.sv
// smaesh_sched: sequencer placed in front of a masked AES core.
// It fetches a fresh 80-bit PRNG seed and hands it to the core. It then
// forwards one key of d shares, one data block, and waits for the core's
// output handshake. Every RESEED_PERIOD completed executions it loops back
// to fetch a new seed.
module smaesh_sched #(
    parameter int d             = 2,
    parameter int RESEED_PERIOD = 256
) (
    input  logic        clk,
    input  logic        rst,

    // host key channel
    input  logic        h_key_valid,
    output logic        h_key_ready,
    input  logic [31:0] h_key_data,
    input  logic [1:0]  h_key_size_cfg,
    input  logic        h_key_inverse,

    // host data channel (payload travels outside this block)
    input  logic        h_data_valid,
    output logic        h_data_ready,

    // seed source
    input  logic        seed_src_valid,
    output logic        seed_src_ready,
    input  logic [79:0] seed_src_data,

    // core key channel
    output logic        core_key_valid,
    input  logic        core_key_ready,
    output logic [31:0] core_key_data,
    output logic [1:0]  core_key_size_cfg,
    output logic        core_key_inverse,

    // core data and seed channels
    output logic        core_data_valid,
    input  logic        core_data_ready,
    output logic        core_seed_valid,
    input  logic        core_seed_ready,
    output logic [79:0] core_seed,

    // core output handshake, observed only
    input  logic        core_out_valid,
    input  logic        core_out_ready,

    // status
    output logic        busy,
    output logic [15:0] exec_cnt,
    output logic        err_cfg
);

    // Key word counter must reach d*8, the largest key of d shares.
    localparam int KCW = $clog2(d * 8 + 1);
    // The since-reseed counter saturates at RESEED_PERIOD.
    localparam int SW  = (RESEED_PERIOD > 0) ? $clog2(RESEED_PERIOD + 1) : 1;

    typedef enum logic [2:0] {
        SEED_GET,
        SEED_PUT,
        IDLE,
        KEY,
        DATA,
        WAIT
    } state_t;

    state_t          state_reg;
    logic [79:0]     seed_reg;
    logic            seed_ready_reg;
    logic            seed_valid_reg;
    logic [1:0]      cfg_reg;
    logic            inverse_reg;
    logic            err_cfg_reg;
    logic [KCW-1:0]  key_cnt_reg;
    logic [15:0]     exec_cnt_reg;
    logic [SW-1:0]   since_reg;

    logic [KCW-1:0]  key_total;
    logic            key_last;
    logic            reseed_due;
    logic            since_full;

    // Number of 32-bit words in the key of the current execution, all shares included.
    always_comb begin
        key_total = KCW'(d * 8);
        case (cfg_reg)
            2'b00:   key_total = KCW'(d * 4);
            2'b01:   key_total = KCW'(d * 6);
            2'b10:   key_total = KCW'(d * 8);
            default: key_total = KCW'(d * 8);
        endcase
    end

    assign key_last   = (key_cnt_reg == (key_total - KCW'(1)));
    assign since_full = (since_reg == SW'(RESEED_PERIOD));
    // With a period of 0 the only seed is the one fetched after reset.
    assign reseed_due = (RESEED_PERIOD != 0) && since_full;

    // Sequencer: state, latched seed/config, handshake flags and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= SEED_GET;
            seed_reg       <= '0;
            seed_ready_reg <= 1'b0;
            seed_valid_reg <= 1'b0;
            cfg_reg        <= 2'b00;
            inverse_reg    <= 1'b0;
            err_cfg_reg    <= 1'b0;
            key_cnt_reg    <= '0;
            exec_cnt_reg   <= '0;
            since_reg      <= '0;
        end else begin
            case (state_reg)
                SEED_GET: begin
                    if (seed_ready_reg && seed_src_valid) begin
                        seed_reg       <= seed_src_data;
                        seed_ready_reg <= 1'b0;
                        seed_valid_reg <= 1'b1;
                        state_reg      <= SEED_PUT;
                    end else begin
                        // First cycle after reset: open the seed source.
                        seed_ready_reg <= 1'b1;
                    end
                end

                SEED_PUT: begin
                    if (core_seed_ready) begin
                        seed_valid_reg <= 1'b0;
                        since_reg      <= '0;
                        state_reg      <= IDLE;
                    end
                end

                IDLE: begin
                    if (reseed_due) begin
                        seed_ready_reg <= 1'b1;
                        state_reg      <= SEED_GET;
                    end else if (h_key_valid) begin
                        // The config is captured here. The first key word
                        // moves in the KEY state.
                        cfg_reg     <= h_key_size_cfg;
                        inverse_reg <= h_key_inverse;
                        if (h_key_size_cfg == 2'b11) begin
                            err_cfg_reg <= 1'b1;
                        end
                        key_cnt_reg <= '0;
                        state_reg   <= KEY;
                    end
                end

                KEY: begin
                    if (h_key_valid && core_key_ready) begin
                        if (key_last) begin
                            key_cnt_reg <= '0;
                            state_reg   <= DATA;
                        end else begin
                            key_cnt_reg <= key_cnt_reg + KCW'(1);
                        end
                    end
                end

                DATA: begin
                    if (h_data_valid && core_data_ready) begin
                        state_reg <= WAIT;
                    end
                end

                WAIT: begin
                    if (core_out_valid && core_out_ready) begin
                        exec_cnt_reg <= exec_cnt_reg + 16'd1;
                        if (RESEED_PERIOD != 0 && !since_full) begin
                            since_reg <= since_reg + SW'(1);
                        end
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= SEED_GET;
                end
            endcase
        end
    end

    // Key and data channels are wired straight through only in their own state.
    always_comb begin
        h_key_ready     = 1'b0;
        core_key_valid  = 1'b0;
        core_key_data   = '0;
        h_data_ready    = 1'b0;
        core_data_valid = 1'b0;
        if (state_reg == KEY) begin
            h_key_ready    = core_key_ready;
            core_key_valid = h_key_valid;
            core_key_data  = h_key_data;
        end
        if (state_reg == DATA) begin
            h_data_ready    = core_data_ready;
            core_data_valid = h_data_valid;
        end
    end

    assign core_key_size_cfg = cfg_reg;
    assign core_key_inverse  = inverse_reg;
    assign seed_src_ready    = seed_ready_reg;
    assign core_seed_valid   = seed_valid_reg;
    assign core_seed         = seed_reg;
    assign busy              = (state_reg != IDLE);
    assign exec_cnt          = exec_cnt_reg;
    assign err_cfg           = err_cfg_reg;

endmodule

// File: tb/tb_smaesh_sched.sv
// Directed bench for smaesh_sched (d=2, RESEED_PERIOD=2).
module tb_smaesh_sched;

    localparam int PERIOD = 2;

    logic        clk;
    logic        rst;
    logic        h_key_valid;
    logic        h_key_ready;
    logic [31:0] h_key_data;
    logic [1:0]  h_key_size_cfg;
    logic        h_key_inverse;
    logic        h_data_valid;
    logic        h_data_ready;
    logic        seed_src_valid;
    logic        seed_src_ready;
    logic [79:0] seed_src_data;
    logic        core_key_valid;
    logic        core_key_ready;
    logic [31:0] core_key_data;
    logic [1:0]  core_key_size_cfg;
    logic        core_key_inverse;
    logic        core_data_valid;
    logic        core_data_ready;
    logic        core_seed_valid;
    logic        core_seed_ready;
    logic [79:0] core_seed;
    logic        core_out_valid;
    logic        core_out_ready;
    logic        busy;
    logic [15:0] exec_cnt;
    logic        err_cfg;

    smaesh_sched #(.d(2), .RESEED_PERIOD(PERIOD)) dut (
        .clk               (clk),
        .rst               (rst),
        .h_key_valid       (h_key_valid),
        .h_key_ready       (h_key_ready),
        .h_key_data        (h_key_data),
        .h_key_size_cfg    (h_key_size_cfg),
        .h_key_inverse     (h_key_inverse),
        .h_data_valid      (h_data_valid),
        .h_data_ready      (h_data_ready),
        .seed_src_valid    (seed_src_valid),
        .seed_src_ready    (seed_src_ready),
        .seed_src_data     (seed_src_data),
        .core_key_valid    (core_key_valid),
        .core_key_ready    (core_key_ready),
        .core_key_data     (core_key_data),
        .core_key_size_cfg (core_key_size_cfg),
        .core_key_inverse  (core_key_inverse),
        .core_data_valid   (core_data_valid),
        .core_data_ready   (core_data_ready),
        .core_seed_valid   (core_seed_valid),
        .core_seed_ready   (core_seed_ready),
        .core_seed         (core_seed),
        .core_out_valid    (core_out_valid),
        .core_out_ready    (core_out_ready),
        .busy              (busy),
        .exec_cnt          (exec_cnt),
        .err_cfg           (err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cfg;
        logic        inv;
        logic [31:0] base;
        bit          alt;        // toggle core_key_ready every cycle
        int          exp_words;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];
    int   vec_cnt;
    int   err_cnt;
    int   model_exec;
    int   model_since;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one seed, then check that the core sees it until it is accepted.
    // Entered just after a rising edge; returns just after a rising edge in IDLE.
    task automatic do_seed(input logic [79:0] s);
        bit got;
        got = 0;
        seed_src_valid  = 1'b1;
        seed_src_data   = s;
        core_seed_ready = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (seed_src_ready) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("seed_src_ready_seen", got, 1'b1);
        @(posedge clk); #1;
        seed_src_valid = 1'b0;
        seed_src_data  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("core_seed_valid_hold", core_seed_valid, 1'b1);
            chk("core_seed_value", core_seed, s);
            chk("seed_src_ready_put", seed_src_ready, 1'b0);
            chk("h_key_ready_seed", h_key_ready, 1'b0);
            @(posedge clk); #1;
        end
        core_seed_ready = 1'b1;
        @(negedge clk);
        chk("core_seed_valid_hs", core_seed_valid, 1'b1);
        @(posedge clk); #1;
        core_seed_ready = 1'b0;
        #1;
        chk("core_seed_valid_done", core_seed_valid, 1'b0);
        chk("busy_after_seed", busy, 1'b0);
    endtask

    // One complete execution. Entered just after a rising edge with the DUT in IDLE.
    task automatic run_exec(input vec_t v);
        int  cnt;
        bit  done;
        bit  hs;
        h_key_valid     = 1'b1;
        h_key_size_cfg  = v.cfg;
        h_key_inverse   = v.inv;
        h_key_data      = v.base;
        core_key_ready  = 1'b1;
        h_data_valid    = 1'b1;
        core_data_ready = 1'b0;
        // Output handshakes outside WAIT must be ignored.
        core_out_valid  = 1'b1;
        core_out_ready  = 1'b1;
        if (model_since == PERIOD) begin
            @(negedge clk);
            chk("idle_before_reseed", busy, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("reseed_seed_get", seed_src_ready, 1'b1);
            chk("reseed_busy", busy, 1'b1);
            chk("reseed_key_blocked", h_key_ready, 1'b0);
            @(posedge clk); #1;
            do_seed(80'hFEDC_BA98_7654_3210_AA55);
            model_since = 0;
        end
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_no_word", h_key_ready, 1'b0);
        @(posedge clk); #1;
        cnt  = 0;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (core_data_valid) done = 1;
            else begin
                if (n == 0) begin
                    chk("key_cfg", core_key_size_cfg, v.cfg);
                    chk("key_inverse", core_key_inverse, v.inv);
                end
                chk("key_valid_pt", core_key_valid, 1'b1);
                chk("key_ready_pt", h_key_ready, core_key_ready);
                if (h_key_ready) begin
                    chk("key_word", core_key_data, v.base + cnt);
                    cnt++;
                end
                @(posedge clk); #1;
                h_key_data     = v.base + cnt;
                core_key_ready = v.alt ? ~core_key_ready : 1'b1;
            end
        end
        chk("data_reached", done, 1'b1);
        chk("key_words", cnt, v.exp_words);
        chk("err_cfg", err_cfg, v.exp_err);
        chk("exec_not_counted", exec_cnt, model_exec);
        core_key_ready = 1'b1;
        #1;
        chk("key_ready_in_data", h_key_ready, 1'b0);
        chk("data_ready_low", h_data_ready, 1'b0);
        @(posedge clk); #1;
        core_data_ready = 1'b1;
        #1;
        chk("data_ready_follow", h_data_ready, 1'b1);
        @(posedge clk); #1;
        h_key_valid = 1'b0;
        #1;
        chk("data_valid_in_wait", core_data_valid, 1'b0);
        chk("data_ready_in_wait", h_data_ready, 1'b0);
        h_data_valid    = 1'b0;
        core_data_ready = 1'b0;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            core_out_valid = 1'b1;
            core_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("exec_in_wait", exec_cnt, model_exec);
            chk("busy_in_wait", busy, 1'b1);
            hs = core_out_ready;
            @(posedge clk); #1;
            if (hs) done = 1;
        end
        chk("out_hs_seen", done, 1'b1);
        model_exec = (model_exec + 1) & 16'hFFFF;
        if (model_since < PERIOD) model_since++;
        core_out_valid = 1'b0;
        core_out_ready = 1'b0;
        #1;
        chk("exec_cnt", exec_cnt, model_exec);
        chk("busy_idle", busy, 1'b0);
    endtask

    // Hold reset for a few cycles, release it, and check that seed_src_ready opens one edge later.
    task automatic reset_release();
        repeat (2) begin
            @(negedge clk);
            chk("rst_seed_ready", seed_src_ready, 1'b0);
            chk("rst_seed_valid", core_seed_valid, 1'b0);
            chk("rst_key_valid", core_key_valid, 1'b0);
            chk("rst_exec_cnt", exec_cnt, 16'd0);
            chk("rst_err_cfg", err_cfg, 1'b0);
            chk("rst_core_seed", core_seed, 80'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("seed_ready_cycle0", seed_src_ready, 1'b0);
        @(posedge clk); #1;
        #1;
        chk("seed_ready_cycle1", seed_src_ready, 1'b1);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        model_exec  = 0;
        model_since = 0;
        vecs[0] = '{2'b00, 1'b1, 32'hA000_0000, 1'b0, 8,  1'b0};
        vecs[1] = '{2'b01, 1'b0, 32'hB000_0010, 1'b1, 12, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 32'hC000_0100, 1'b0, 16, 1'b0};
        vecs[3] = '{2'b00, 1'b0, 32'hD000_1000, 1'b1, 8,  1'b0};
        vecs[4] = '{2'b11, 1'b1, 32'hE001_0000, 1'b0, 16, 1'b1};

        rst             = 1'b0;
        h_key_valid     = 1'b1;
        h_key_data      = '0;
        h_key_size_cfg  = 2'b00;
        h_key_inverse   = 1'b0;
        h_data_valid    = 1'b1;
        seed_src_valid  = 1'b0;
        seed_src_data   = '0;
        core_key_ready  = 1'b1;
        core_data_ready = 1'b1;
        core_seed_ready = 1'b0;
        core_out_valid  = 1'b0;
        core_out_ready  = 1'b0;

        reset_release();
        h_key_valid = 1'b0;
        h_data_valid = 1'b0;
        core_data_ready = 1'b0;
        do_seed(80'h0123456789ABCDEF0011);

        for (int i = 0; i < 5; i++) begin
            run_exec(vecs[i]);
            $display("exec %0d cfg=%0b inv=%0b exec_cnt=%0d err_cfg=%0b", i, vecs[i].cfg, vecs[i].inv, exec_cnt, err_cfg);
        end

        // Reset in the middle of a key transfer, after three of eight words.
        h_key_valid    = 1'b1;
        h_key_size_cfg = 2'b00;
        h_key_inverse  = 1'b1;
        h_key_data     = 32'h5500_0000;
        core_key_ready = 1'b1;
        h_data_valid   = 1'b1;
        core_data_ready = 1'b1;
        @(negedge clk);
        chk("mid_idle", busy, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            h_key_data = 32'h5500_0000 + i;
            @(negedge clk);
            chk("mid_key_ready", h_key_ready, 1'b1);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_key_valid", core_key_valid, 1'b0);
        chk("mid_rst_key_ready", h_key_ready, 1'b0);
        chk("mid_rst_data_valid", core_data_valid, 1'b0);
        chk("mid_rst_data_ready", h_data_ready, 1'b0);
        chk("mid_rst_seed_ready", seed_src_ready, 1'b0);
        chk("mid_rst_seed_valid", core_seed_valid, 1'b0);
        chk("mid_rst_exec_cnt", exec_cnt, 16'd0);
        chk("mid_rst_err_cfg", err_cfg, 1'b0);
        $display("mid-transfer reset applied exec_cnt=%0d err_cfg=%0b", exec_cnt, err_cfg);
        reset_release();
        h_key_valid = 1'b0;
        h_data_valid = 1'b0;
        core_data_ready = 1'b0;
        model_exec  = 0;
        model_since = 0;
        do_seed(80'h1111_2222_3333_4444_5555);
        run_exec(vecs[0]);
        $display("post-reset exec exec_cnt=%0d err_cfg=%0b", exec_cnt, err_cfg);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/smaesh_sched.md
SMAESH_SCHED -- requirements
Module: smaesh_sched

Interface
REQ-001 The block SHALL have parameter d, default 2, meaning number of shares.
REQ-002 The block SHALL have parameter RESEED_PERIOD, default 256, meaning completed executions between PRNG reseeds; 0 means reseed once after reset only.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have host key ports: h_key_valid in 1, h_key_ready out 1, h_key_data in 32, h_key_size_cfg in 2, h_key_inverse in 1.
REQ-006 The block SHALL have host data ports: h_data_valid in 1, h_data_ready out 1.
REQ-007 The block SHALL have seed source ports: seed_src_valid in 1, seed_src_ready out 1, seed_src_data in 80.
REQ-008 The block SHALL have core key ports: core_key_valid out 1, core_key_ready in 1, core_key_data out 32, core_key_size_cfg out 2, core_key_inverse out 1.
REQ-009 The block SHALL have core data and seed ports: core_data_valid out 1, core_data_ready in 1, core_seed_valid out 1, core_seed_ready in 1, core_seed out 80.
REQ-010 The block SHALL have core output monitor ports: core_out_valid in 1, core_out_ready in 1.
REQ-011 The block SHALL have status ports: busy out 1, exec_cnt out 16, err_cfg out 1.

Function
REQ-012 The FSM SHALL have states SEED_GET, SEED_PUT, IDLE, KEY, DATA and WAIT; it SHALL enter SEED_GET on reset.
REQ-013 In SEED_GET, seed_src_ready SHALL be 1; on a seed_src handshake, seed_src_data SHALL be latched and the FSM SHALL go to SEED_PUT.
REQ-014 In SEED_PUT, core_seed_valid SHALL be 1 with the latched seed; on a core_seed handshake, the FSM SHALL go to IDLE and the since-reseed counter SHALL clear.
REQ-015 In IDLE, a pending reseed (RESEED_PERIOD != 0 and since-reseed count == RESEED_PERIOD) SHALL take priority: the FSM SHALL go to SEED_GET, and h_key_valid SHALL be ignored.
REQ-016 In IDLE with no pending reseed and h_key_valid=1, the block SHALL latch h_key_size_cfg and h_key_inverse, go to KEY the next cycle and consume no word in that cycle.
REQ-017 In KEY, the key interface SHALL be combinational pass-through: core_key_valid=h_key_valid, h_key_ready=core_key_ready, core_key_data=h_key_data; cfg and inverse SHALL come from the latched values.
REQ-018 KEY SHALL count key handshakes up to d*KWORDS, where KWORDS is 4/6/8 for cfg 00/01/10; cfg 11 SHALL use 8 and set err_cfg sticky.
REQ-019 After the last key handshake, the FSM SHALL go to DATA; h_key_ready SHALL be 0 outside KEY.
REQ-020 In DATA, the block SHALL pass through core_data_valid=h_data_valid and h_data_ready=core_data_ready; on a handshake, the FSM SHALL go to WAIT. Outside DATA, both SHALL be 0.
REQ-021 In WAIT, a handshake core_out_valid and core_out_ready SHALL increment exec_cnt (wraps 0xFFFF->0) and the since-reseed count (saturating at RESEED_PERIOD), and the FSM SHALL go to IDLE.
REQ-022 Output handshakes outside WAIT SHALL be ignored.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 All state changes SHALL occur on the rising edge of clk; there SHALL be no combinational path from core_* inputs to seed_src_ready.

Reset
REQ-025 While rst=0, the block SHALL hold: state SEED_GET, latched seed/cfg/inverse and counters 0, err_cfg 0.
REQ-026 During reset, every valid/ready output SHALL be 0 (seed_src_ready rises the first cycle after rst=1).
REQ-027 Reset asserted mid-operation SHALL take effect immediately, asynchronously, and abort any partial key transfer.

Verification
REQ-028 Reset release, seed 80'h0123456789ABCDEF0011 offered -> seed_src_ready=1 in cycle 1, core_seed equals that value with core_seed_valid=1 until core_seed_ready, then busy=0.
REQ-029 d=2, cfg 00, inverse 1, core ready always -> exactly 8 key words forwarded in order, core_key_inverse=1, h_key_ready=0 after the 8th, then h_data_ready follows core_data_ready.
REQ-030 RESEED_PERIOD=2, two full executions -> after the 2nd output handshake the FSM enters SEED_GET; h_key_valid held high is not accepted until the new seed is consumed.
REQ-031 core_out_ready random 50% -> exec_cnt increments only on output handshakes in WAIT; core_out_valid pulses outside WAIT do not count.
REQ-032 rst pulled low after 3 of 8 key words -> all valid/ready outputs are 0 immediately; after release, the sequence restarts at SEED_GET with exec_cnt=0.
REQ-033 cfg 11, d=2 -> err_cfg=1 and 16 words are consumed before DATA.
